stall_data_mem: RTL and testbench
=================================

// Module: stall_data_mem
// PURPOSE
//  Multi-cycle word-addressed data-memory responder serving the Memory stage.
//  - Accepts one read or write request at a time and completes it after a fixed latency.
//  - Reports completion with a one-cycle Done pulse and holds Stall while busy.
//  - Flags illegal requests with Err; the pipeline uses Stall/Done to freeze the Memory stage.
// PARAMETERS
//  N       16  address and data width in bits (byte address)
//  ADDR_W  8   word-index width; array holds 2**ADDR_W words of N bits
//  LAT     4   cycles from request acceptance to Done (LAT >= 1)
// PORTS
//  clk      input   1       clock; all state updates on rising edge
//  rst      input   1       reset, synchronous, active-low (0 = reset)
//  Addr     input   N       byte address of request
//  DataIn   input   N       write data
//  Rd       input   1       read request
//  Wr       input   1       write request
//  DataOut  output  N       read data; valid only in the Done cycle of a read
//  Done     output  1       one-cycle completion pulse
//  Stall    output  1       1 while a request is in flight (state != IDLE)
//  Err      output  1       one-cycle pulse: illegal request rejected
// BEHAVIOUR
//  Reset (rst==0 at an edge)
//   - State=IDLE; DataOut=0, Done=0, Stall=0, Err=0.
//   - All array words are zeroed.
//   - An in-flight request is aborted and its pending write is discarded.
//  States: IDLE, BUSY, DONE. All outputs are registered.
//  IDLE
//   - Rd^Wr with Addr[0]==0: latch Addr[ADDR_W:1], DataIn and op; load count=LAT-1.
//     Go BUSY, or go DONE directly if LAT==1.
//   - Rd&Wr, or Addr[0]==1 with Rd|Wr: Err=1 for the next cycle only.
//     No access occurs; state stays IDLE.
//   - No request: stay IDLE.
//  BUSY
//   - count decrements each cycle; at count==1 -> DONE.
//   - Rd/Wr/Addr/DataIn are ignored; the latched values are used.
//  DONE (exactly one cycle)
//   - Done=1.
//   - Read: DataOut = mem[latched index], sampled on the BUSY->DONE edge.
//   - Write: mem[latched index] <= latched data on the entering edge; DataOut=0.
//   - Next state is always IDLE. Requests present in this cycle are ignored.
//  Timing and outputs
//   - Request accepted at edge T gives Done high in cycle T+LAT.
//   - Stall is high from cycle T+1 through the Done cycle inclusive.
//   - Minimum spacing between accepted requests: LAT+1 cycles.
//   - DataOut returns to 0 the cycle after Done.
//  Addressing
//   - Word index = Addr[ADDR_W:1]; bits above ADDR_W are ignored (aliasing).
//   - Example with ADDR_W=8: 0x0202 and 0x0002 hit the same word.
//  Read-after-write
//   - A read issued after a write's Done returns the new data.
// TESTING
//  1. Reset then Rd Addr=0x0010 -> Done at cycle T+4, DataOut=0x0000, Stall high cycles T+1..T+4.
//  2. Wr Addr=0x0020 DataIn=0xBEEF, then Rd 0x0020 -> read Done with DataOut=0xBEEF.
//  3. Rd&Wr asserted together, or Rd Addr=0x0011 -> Err pulse 1 cycle, Stall=0, no Done, memory unchanged.
//  4. Wr 0x0202=0x1234, then Rd 0x0002 -> DataOut=0x1234 (alias/wrap).
//  5. Wr 0x0030=0xAAAA accepted, rst=0 in BUSY -> outputs 0 next cycle; later Rd 0x0030 -> 0x0000.
//  6. Hold Rd high continuously with LAT=1 -> Done every 2nd cycle; new Addr/DataIn during BUSY ignored.

Source files
------------

// File: rtl/stall_data_mem_if.sv
// Request/response bundle between the Memory stage and the data-memory responder.
// Latency: none; plain wires only.
// Backpressure: none in the bundle; the responder reports busy through Stall.
interface stall_data_mem_if #(
    parameter int N = 16
);
    logic [N-1:0] Addr;
    logic [N-1:0] DataIn;
    logic         Rd;
    logic         Wr;
    logic [N-1:0] DataOut;
    logic         Done;
    logic         Stall;
    logic         Err;

    // Pipeline side: issues requests and watches completion.
    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, Err
    );

    // Memory side: accepts requests and reports completion.
    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, Err
    );
endinterface

// File: rtl/stall_data_mem.sv
// Multi-cycle word-addressed data memory for the Memory stage; one request at a time.
// Latency: Done pulses LAT cycles after the accepting edge; all outputs registered.
// Backpressure: Stall is high while a request is in flight; requests seen then are ignored.
module stall_data_mem #(
    parameter int N      = 16,
    parameter int ADDR_W = 8,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    stall_data_mem_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // count holds at most LAT-1
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [ADDR_W-1:0]   idx_q, idx_nxt;
    logic [N-1:0]        data_q, data_nxt;
    logic                wr_q, wr_nxt;

    logic [N-1:0]        mem [2**ADDR_W];

    logic                req_ok;
    logic                req_bad;
    logic                err_nxt;
    logic                enter_done;
    logic [ADDR_W-1:0]   acc_idx;
    logic [N-1:0]        acc_data;
    logic                acc_wr;

    // Address bits above the word index alias onto the same word.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[N-1:ADDR_W+1];

    // A legal request is exactly one of Rd/Wr on a word-aligned address.
    assign req_ok  = (bus.Rd ^ bus.Wr) && !bus.Addr[0];
    assign req_bad = (bus.Rd | bus.Wr) && !req_ok;

    // Next-state logic; also selects which index/data the entering-DONE edge uses
    // (fresh bus values when LAT==1 skips BUSY, latched values otherwise).
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        idx_nxt    = idx_q;
        data_nxt   = data_q;
        wr_nxt     = wr_q;
        err_nxt    = 1'b0;
        enter_done = 1'b0;
        acc_idx    = idx_q;
        acc_data   = data_q;
        acc_wr     = wr_q;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    idx_nxt   = bus.Addr[ADDR_W:1];
                    data_nxt  = bus.DataIn;
                    wr_nxt    = bus.Wr;
                    count_nxt = CNT_W'(LAT - 1);
                    if (LAT == 1) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                        acc_idx    = bus.Addr[ADDR_W:1];
                        acc_data   = bus.DataIn;
                        acc_wr     = bus.Wr;
                    end else begin
                        state_nxt = BUSY;
                    end
                end else if (req_bad) begin
                    err_nxt = 1'b1;
                end
            end
            BUSY: begin
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            bus.Done    <= 1'b0;
            bus.Stall   <= 1'b0;
            bus.Err     <= 1'b0;
            bus.DataOut <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            idx_q       <= idx_nxt;
            data_q      <= data_nxt;
            wr_q        <= wr_nxt;
            bus.Done    <= (state_nxt == DONE);
            bus.Stall   <= (state_nxt != IDLE);
            bus.Err     <= err_nxt;
            bus.DataOut <= (enter_done && !acc_wr) ? mem[acc_idx] : '0;
        end
    end

    // Storage array: cleared by reset, written on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (enter_done && acc_wr) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule

// File: tb/tb_stall_data_mem.sv
// Bench for stall_data_mem: directed table, reset-abort and LAT=1 sequences, random traffic.
// Latency: checks Done at exactly LAT cycles after acceptance, Stall across the window.
// Backpressure: drives junk on the inputs while busy to confirm they are ignored.
module tb_stall_data_mem;

    localparam int LAT0 = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stall_data_mem_if #(.N(16)) bus0 ();
    stall_data_mem_if #(.N(16)) bus1 ();

    stall_data_mem #(.N(16), .ADDR_W(8), .LAT(LAT0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    stall_data_mem #(.N(16), .ADDR_W(8), .LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int tests = 0;
    int fails = 0;

    // Reference contents of dut0, indexed by word.
    logic [15:0] model [256];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_err;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on dut0 with cycle-by-cycle checks of the whole transaction.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] din, input logic exp_err,
                         input logic [15:0] exp_data, input string tag);
        @(negedge clk);
        bus0.Rd = rd; bus0.Wr = wr; bus0.Addr = addr; bus0.DataIn = din;
        if (exp_err) begin
            @(negedge clk);
            bus0.Rd = 1'b0; bus0.Wr = 1'b0;
            chk({tag, " err_pulse"}, bus0.Err, 1);
            chk({tag, " err_stall"}, bus0.Stall, 0);
            chk({tag, " err_done"}, bus0.Done, 0);
            @(negedge clk);
            chk({tag, " err_clear"}, bus0.Err, 0);
            chk({tag, " err_nodone"}, bus0.Done, 0);
        end else begin
            if (wr) model[addr[8:1]] = din;
            for (int k = 1; k <= LAT0; k++) begin
                @(negedge clk);
                chk({tag, " stall"}, bus0.Stall, 1);
                chk({tag, " done"}, bus0.Done, (k == LAT0) ? 1 : 0);
                if (k == LAT0) chk({tag, " data"}, bus0.DataOut, exp_data);
                bus0.Rd     = 1'($urandom);
                bus0.Wr     = 1'($urandom);
                bus0.Addr   = 16'($urandom);
                bus0.DataIn = 16'($urandom);
            end
            @(negedge clk);
            bus0.Rd = 1'b0; bus0.Wr = 1'b0;
            chk({tag, " idle_stall"}, bus0.Stall, 0);
            chk({tag, " idle_done"}, bus0.Done, 0);
            chk({tag, " idle_data"}, bus0.DataOut, 0);
            chk({tag, " idle_err"}, bus0.Err, 0);
        end
    endtask

    // Single write on the LAT=1 instance.
    task automatic wr1(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus1.Wr = 1'b1; bus1.Addr = a; bus1.DataIn = d;
        @(negedge clk);
        bus1.Wr = 1'b0;
        chk("l1_wr_done", bus1.Done, 1);
        @(negedge clk);
        chk("l1_wr_idle", bus1.Done, 0);
    endtask

    logic        r_rd, r_wr, r_err;
    logic [15:0] r_addr, r_din, r_exp;
    int          op;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
        tbl[3]  = '{1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000};
        tbl[5]  = '{1'b0, 1'b1, 16'h0021, 16'h2222, 1'b1, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
        tbl[7]  = '{1'b0, 1'b1, 16'h0202, 16'h1234, 1'b0, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h1234};
        tbl[9]  = '{1'b0, 1'b1, 16'hFE02, 16'hABCD, 1'b0, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hABCD};

        rst = 1'b0;
        bus0.Rd = 1'b0; bus0.Wr = 1'b0; bus0.Addr = '0; bus0.DataIn = '0;
        bus1.Rd = 1'b0; bus1.Wr = 1'b0; bus1.Addr = '0; bus1.DataIn = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", bus0.Done, 0);
        chk("rst_stall", bus0.Stall, 0);
        chk("rst_err", bus0.Err, 0);
        chk("rst_data", bus0.DataOut, 0);
        chk("rst_l1_stall", bus1.Stall, 0);
        rst = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din,
                  tbl[i].exp_err, tbl[i].exp_data, $sformatf("vec%0d", i));
        end

        // Reset while a write is in flight discards the write and clears memory.
        @(negedge clk);
        bus0.Wr = 1'b1; bus0.Addr = 16'h0030; bus0.DataIn = 16'hAAAA;
        @(negedge clk);
        bus0.Wr = 1'b0;
        chk("abort_busy", bus0.Stall, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", bus0.Stall, 0);
        chk("abort_done", bus0.Done, 0);
        chk("abort_err", bus0.Err, 0);
        chk("abort_data", bus0.DataOut, 0);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, "abort_rd");
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, "abort_clr");

        // Random traffic over a small word set so aliasing and read-after-write recur.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            r_addr = 16'($urandom);
            r_addr[8:1] = 8'($urandom_range(0, 7));
            r_addr[0] = 1'b0;
            r_din = 16'($urandom);
            r_rd = (op < 4) || (op >= 8);
            r_wr = (op >= 4) && (op < 9);
            if (op == 9) r_addr[0] = 1'b1;
            r_err = (op >= 8);
            r_exp = (r_rd && !r_wr && !r_err) ? model[r_addr[8:1]] : 16'h0000;
            issue(r_rd, r_wr, r_addr, r_din, r_err, r_exp, $sformatf("rnd%0d", i));
        end

        // LAT=1: continuous Rd completes every second cycle; DONE-cycle inputs ignored.
        wr1(16'h0004, 16'h5A5A);
        wr1(16'h0006, 16'hC3C3);
        @(negedge clk);
        bus1.Rd = 1'b1; bus1.Addr = 16'h0004;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("l1_done", bus1.Done, 1);
            chk("l1_stall", bus1.Stall, 1);
            chk("l1_err", bus1.Err, 0);
            chk("l1_data", bus1.DataOut, (i % 2 == 0) ? 16'h5A5A : 16'hC3C3);
            bus1.Addr = 16'h0003;
            bus1.DataIn = 16'($urandom);
            @(negedge clk);
            chk("l1_gap_done", bus1.Done, 0);
            chk("l1_gap_stall", bus1.Stall, 0);
            chk("l1_gap_err", bus1.Err, 0);
            chk("l1_gap_data", bus1.DataOut, 0);
            bus1.Addr = (i % 2 == 0) ? 16'h0006 : 16'h0004;
        end
        bus1.Rd = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
